// File: rtl/stbuf_fwd.sv
// In-order store buffer with commit/flush, valid-ready retire and byte-granular store-to-load forwarding.
// Latency: allocate visible to loads next cycle, commit to o_ret_vld next cycle; lookup is combinational.
// Backpressure: i_fin_vld ignored while o_full; retire entry held stable until i_ret_rdy. Macro: STBUF_FWD_EN.
module stbuf_fwd #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   localparam int BE_W  = DATA_W / 8,
   localparam int PTR_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_fin_vld,
   input  logic [ADDR_W-1:0] i_fin_addr,
   input  logic [DATA_W-1:0] i_fin_data,
   input  logic [BE_W-1:0]   i_fin_be,
   output logic              o_full,
   output logic              o_empty,
   output logic [PTR_W-1:0]  o_count,
   input  logic              i_com_vld,
   input  logic              i_flush,
   output logic              o_ret_vld,
   input  logic              i_ret_rdy,
   output logic [ADDR_W-1:0] o_ret_addr,
   output logic [DATA_W-1:0] o_ret_data,
   output logic [BE_W-1:0]   o_ret_be,
   input  logic [ADDR_W-1:0] i_ld_addr,
   input  logic [BE_W-1:0]   i_ld_be,
   output logic              o_ld_hit,
   output logic              o_ld_partial,
   output logic [DATA_W-1:0] o_ld_data,
   output logic [BE_W-1:0]   o_ld_fwd_be
);
   localparam int IDX_W = PTR_W - 1;
   localparam int OFF_W = $clog2(BE_W);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [BE_W-1:0]   be;
   } ent_t;

   ent_t             mem [DEPTH];
   logic [DEPTH-1:0] vld, cmt, disc;
   logic [PTR_W-1:0] fin_ptr, com_ptr, ret_ptr, com_nxt, disc_n;
   logic [IDX_W-1:0] fin_idx, com_idx, ret_idx;
   logic             do_alloc, do_com, do_ret;

   function automatic logic word_match(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
      return (a >> OFF_W) == (b >> OFF_W);
   endfunction

   assign fin_idx  = fin_ptr[IDX_W-1:0];
   assign com_idx  = com_ptr[IDX_W-1:0];
   assign ret_idx  = ret_ptr[IDX_W-1:0];
   assign o_empty  = (fin_ptr == ret_ptr);
   assign o_full   = (fin_idx == ret_idx) && (fin_ptr[IDX_W] != ret_ptr[IDX_W]);
   assign o_count  = fin_ptr - ret_ptr;
   assign do_alloc = i_fin_vld && !o_full && !i_flush;
   assign do_com   = i_com_vld && (com_ptr != fin_ptr);
   assign com_nxt  = com_ptr + PTR_W'(do_com);
   assign disc_n   = fin_ptr - com_nxt;
   assign o_ret_vld  = vld[ret_idx] && cmt[ret_idx];
   assign do_ret     = o_ret_vld && i_ret_rdy;
   assign o_ret_addr = mem[ret_idx].addr;
   assign o_ret_data = mem[ret_idx].data;
   assign o_ret_be   = mem[ret_idx].be;

   // Slots between the post-commit pointer and fin are the ones a flush throws away.
   always_comb begin
      disc = '0;
      for (int i = 0; i < DEPTH; i++) begin
         disc[i] = {1'b0, IDX_W'(i) - com_nxt[IDX_W-1:0]} < disc_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fin_ptr <= '0;
         com_ptr <= '0;
         ret_ptr <= '0;
         vld     <= '0;
         cmt     <= '0;
      end else begin
         if (do_ret) begin
            vld[ret_idx] <= 1'b0;
            cmt[ret_idx] <= 1'b0;
            ret_ptr      <= ret_ptr + PTR_W'(1);
         end
         if (do_com) cmt[com_idx] <= 1'b1;
         com_ptr <= com_nxt;
         if (i_flush) begin
            fin_ptr <= com_nxt;
            for (int i = 0; i < DEPTH; i++) begin
               if (disc[i]) vld[i] <= 1'b0;
            end
         end else if (do_alloc) begin
            vld[fin_idx] <= 1'b1;
            fin_ptr      <= fin_ptr + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_alloc) mem[fin_idx] <= '{addr: i_fin_addr, data: i_fin_data, be: i_fin_be};
   end

`ifdef STBUF_FWD_EN
   logic [BE_W-1:0]   cov, fwd_be;
   logic [DATA_W-1:0] fdat;
   logic [IDX_W-1:0]  idx;

   // Walk oldest to youngest so younger stores overwrite older lanes; starting at ret handles wrap.
   always_comb begin
      cov  = '0;
      fdat = '0;
      idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = ret_idx + IDX_W'(k);
         if (vld[idx] && word_match(mem[idx].addr, i_ld_addr)) begin
            for (int l = 0; l < BE_W; l++) begin
               if (mem[idx].be[l]) begin
                  cov[l]          = 1'b1;
                  fdat[8*l +: 8]  = mem[idx].data[8*l +: 8];
               end
            end
         end
      end
   end

   assign fwd_be = cov & i_ld_be;

   always_comb begin
      o_ld_data = '0;
      for (int l = 0; l < BE_W; l++) begin
         if (fwd_be[l]) o_ld_data[8*l +: 8] = fdat[8*l +: 8];
      end
   end

   assign o_ld_fwd_be  = fwd_be;
   assign o_ld_hit     = (|i_ld_be) && (fwd_be == i_ld_be);
   assign o_ld_partial = (|fwd_be) && !o_ld_hit;
`else
   logic conflict;

   always_comb begin
      conflict = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld[i] && word_match(mem[i].addr, i_ld_addr) && |(mem[i].be & i_ld_be)) conflict = 1'b1;
      end
   end

   assign o_ld_hit     = 1'b0;
   assign o_ld_data    = '0;
   assign o_ld_fwd_be  = '0;
   assign o_ld_partial = conflict;
`endif
endmodule

// File: tb/tb_stbuf_fwd.sv
// Directed + short random bench for stbuf_fwd with a queue scoreboard of buffered stores.
// Expected forward results follow STBUF_FWD_EN the same way the design build does.
module tb_stbuf_fwd;
   logic        clk = 1'b0;
   logic        rst;
   logic        i_fin_vld, i_com_vld, i_flush, i_ret_rdy;
   logic [31:0] i_fin_addr, i_fin_data, i_ld_addr;
   logic [3:0]  i_fin_be, i_ld_be;
   logic        o_full, o_empty, o_ret_vld, o_ld_hit, o_ld_partial;
   logic [3:0]  o_count, o_ret_be, o_ld_fwd_be;
   logic [31:0] o_ret_addr, o_ret_data, o_ld_data;

   stbuf_fwd dut (
      .clk(clk), .rst(rst),
      .i_fin_vld(i_fin_vld), .i_fin_addr(i_fin_addr), .i_fin_data(i_fin_data), .i_fin_be(i_fin_be),
      .o_full(o_full), .o_empty(o_empty), .o_count(o_count),
      .i_com_vld(i_com_vld), .i_flush(i_flush),
      .o_ret_vld(o_ret_vld), .i_ret_rdy(i_ret_rdy),
      .o_ret_addr(o_ret_addr), .o_ret_data(o_ret_data), .o_ret_be(o_ret_be),
      .i_ld_addr(i_ld_addr), .i_ld_be(i_ld_be),
      .o_ld_hit(o_ld_hit), .o_ld_partial(o_ld_partial), .o_ld_data(o_ld_data), .o_ld_fwd_be(o_ld_fwd_be)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  b;
   } ent_t;

   ent_t q[$];
   int   ncom = 0;
   int   rp   = 0;
   int   n_assert = 0;
   int   n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, check visible state, fold the cycle into the model.
   task automatic step(input logic fv, input logic [31:0] fa, input logic [31:0] fd, input logic [3:0] fb,
                       input logic cv, input logic fl, input logic rdy);
      int   sz, nc;
      ent_t e;
      i_fin_vld = fv; i_fin_addr = fa; i_fin_data = fd; i_fin_be = fb;
      i_com_vld = cv; i_flush = fl; i_ret_rdy = rdy;
      #1;
      sz = q.size();
      nc = ncom;
      chk("count", 32'(o_count), sz);
      chk("full", 32'(o_full), 32'(sz == 8));
      chk("empty", 32'(o_empty), 32'(sz == 0));
      chk("ret_vld", 32'(o_ret_vld), 32'(nc > 0));
      if (nc > 0) begin
         chk("ret_addr", o_ret_addr, q[0].a);
         chk("ret_data", o_ret_data, q[0].d);
         chk("ret_be", 32'(o_ret_be), 32'(q[0].b));
      end
      if (nc > 0 && rdy) begin
         void'(q.pop_front());
         ncom--;
         rp++;
      end
      if (cv && sz - nc > 0) ncom++;
      if (fl) begin
         while (q.size() > ncom) void'(q.pop_back());
      end else if (fv && sz != 8) begin
         e.a = fa; e.d = fd; e.b = fb;
         q.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, rdy);
   endtask

   task automatic ld_exp(input string tag, input logic [31:0] a, input logic [3:0] b,
                         input logic eh, input logic ep, input logic [31:0] ed);
      i_ld_addr = a; i_ld_be = b;
      #1;
      chk({tag, "_hit"}, 32'(o_ld_hit), 32'(eh));
      chk({tag, "_partial"}, 32'(o_ld_partial), 32'(ep));
      chk({tag, "_data"}, o_ld_data, ed);
   endtask

   // Reference lookup over the scoreboard contents, oldest to youngest.
   task automatic ld_mdl(input logic [31:0] a, input logic [3:0] b);
      logic [3:0]  cov, fbe;
      logic [31:0] dat, md;
      logic        conf, hit;
      cov = '0; dat = '0; conf = 1'b0; md = '0;
      foreach (q[i]) begin
         if (q[i].a[31:2] == a[31:2]) begin
            if ((q[i].b & b) != 4'h0) conf = 1'b1;
            for (int l = 0; l < 4; l++) begin
               if (q[i].b[l]) begin
                  cov[l] = 1'b1;
                  dat[8*l +: 8] = q[i].d[8*l +: 8];
               end
            end
         end
      end
      fbe = cov & b;
      for (int l = 0; l < 4; l++) if (fbe[l]) md[8*l +: 8] = dat[8*l +: 8];
      hit = (b != 4'h0) && (fbe == b);
      i_ld_addr = a; i_ld_be = b;
      #1;
`ifdef STBUF_FWD_EN
      chk("mdl_hit", 32'(o_ld_hit), 32'(hit));
      chk("mdl_partial", 32'(o_ld_partial), 32'(fbe != 4'h0 && !hit));
      chk("mdl_data", o_ld_data, md);
      chk("mdl_fwd_be", 32'(o_ld_fwd_be), 32'(fbe));
`else
      chk("mdl_hit", 32'(o_ld_hit), 32'h0);
      chk("mdl_partial", 32'(o_ld_partial), 32'(conf));
      chk("mdl_data", o_ld_data, 32'h0);
      chk("mdl_fwd_be", 32'(o_ld_fwd_be), 32'h0);
`endif
   endtask

   task automatic drain();
      for (int n = 0; n < 20 && q.size() > 0; n++) step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1);
      chk("drained", 32'(q.size()), 32'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      i_fin_vld = 0; i_com_vld = 0; i_flush = 0; i_ret_rdy = 0;
      i_fin_addr = '0; i_fin_data = '0; i_fin_be = '0; i_ld_addr = '0; i_ld_be = '0;
      @(posedge clk); @(posedge clk); @(negedge clk);
      rst = 1'b0;
      q.delete();
      ncom = 0;
      rp = 0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      do_reset();
      chk("rst_count", 32'(o_count), 32'h0);
      chk("rst_empty", 32'(o_empty), 32'h1);
      chk("rst_full", 32'(o_full), 32'h0);
      chk("rst_ret_vld", 32'(o_ret_vld), 32'h0);
      ld_exp("rst_ld", 32'h100, 4'hF, 1'b0, 1'b0, 32'h0);
      chk("rst_fwd_be", 32'(o_ld_fwd_be), 32'h0);

      // Fill without commits, then one ignored allocate.
      for (int k = 0; k < 8; k++) step(1'b1, 32'h100 + 32'(4 * k), 32'hA000 + 32'(k), 4'hF, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h900, 32'hDEAD, 4'hF, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      chk("t1_count", 32'(o_count), 32'h8);
      ld_mdl(32'h104, 4'hF);

      // Commit three, hold retire off, then retire back to back.
      for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      for (int k = 0; k < 3; k++) idle(1'b1);
      idle(1'b0);
      chk("t2_count", 32'(o_count), 32'h5);
      drain();

      // Sub-word merge; second store younger.
      step(1'b1, 32'h200, 32'h11223344, 4'hF, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h200, 32'h000000AA, 4'h1, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
`ifdef STBUF_FWD_EN
      ld_exp("t3_full", 32'h202, 4'hF, 1'b1, 1'b0, 32'h112233AA);
`else
      ld_exp("t3_full", 32'h202, 4'hF, 1'b0, 1'b1, 32'h0);
`endif
      ld_exp("t3_zero_be", 32'h200, 4'h0, 1'b0, 1'b0, 32'h0);
      ld_exp("t3_other", 32'h204, 4'hF, 1'b0, 1'b0, 32'h0);
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1);
      idle(1'b0);
`ifdef STBUF_FWD_EN
      ld_exp("t3_part", 32'h200, 4'h3, 1'b0, 1'b1, 32'h000000AA);
      chk("t3_part_fbe", 32'(o_ld_fwd_be), 32'h1);
`else
      ld_exp("t3_part", 32'h200, 4'h3, 1'b0, 1'b1, 32'h0);
`endif
      drain();

      // Flush with same-cycle commit and allocate.
      for (int k = 0; k < 5; k++) step(1'b1, 32'h300 + 32'(4 * k), 32'hB000 + 32'(k), 4'hF, 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h3F0, 32'hBAD0, 4'hF, 1'b1, 1'b1, 1'b0);
      chk("t4_count", 32'(o_count), 32'h3);
      ld_mdl(32'h30C, 4'hF);
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h380, 32'hC0DE, 4'hF, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) idle(1'b1);
      chk("t4_left", 32'(o_count), 32'h1);
      drain();

      // Random traffic over two words so the pointers wrap.
      for (int k = 0; k < 20; k++) begin
         step(1'($urandom_range(0, 1)), 32'h400 + 32'(4 * $urandom_range(0, 1)), $urandom,
              4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
         ld_mdl(32'h400 + 32'(4 * $urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end
      drain();

      // Place two same-word stores in the last and first slots.
      for (int n = 0; n < 16 && (rp % 8) != 7; n++) begin
         step(1'b1, 32'h600, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0);
         drain();
      end
      chk("t5_slot", 32'(rp % 8), 32'h7);
      step(1'b1, 32'h500, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h500, 32'h0000CAFE, 4'h3, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
`ifdef STBUF_FWD_EN
      ld_exp("t5_wrap", 32'h501, 4'hF, 1'b1, 1'b0, 32'hDEADCAFE);
`else
      ld_exp("t5_wrap", 32'h501, 4'hF, 1'b0, 1'b1, 32'h0);
`endif
      ld_mdl(32'h500, 4'h6);

      // Reset with committed entries in flight.
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
      do_reset();
      chk("rst2_count", 32'(o_count), 32'h0);
      chk("rst2_ret_vld", 32'(o_ret_vld), 32'h0);
      ld_exp("rst2_ld", 32'h500, 4'hF, 1'b0, 1'b0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/stbuf_fwd.md
Name: stbuf_fwd

Overview:
Parametrised store buffer that holds executed stores between execute-finish and memory write, in program order. Each entry carries a byte mask, so sub-word stores are supported. Adds a speculative flush of finished-but-uncommitted entries, a valid/ready retire handshake to the data-memory port, and byte-granular youngest-first store-to-load forwarding. Sits between the store execution unit / commit logic and the dmem write arbiter.

Parameters:
DEPTH, 8, number of entries; power of 2, >= 2
ADDR_W, 32, address width; addresses compared word-aligned (low log2(DATA_W/8) bits ignored)
DATA_W, 32, data width; multiple of 8; BE_W = DATA_W/8 (derived localparam)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_fin_vld  in  1  store finished execution; allocate entry at fin pointer
i_fin_addr  in  ADDR_W  store address
i_fin_data  in  DATA_W  store data, byte lanes already aligned
i_fin_be  in  BE_W  store byte enables
o_full  out  1  no free entry; registered-state based
o_empty  out  1  no valid entry
o_count  out  log2(DEPTH)+1  number of valid entries
i_com_vld  in  1  oldest uncommitted store committed by ROB
i_flush  in  1  discard all finished, uncommitted entries
o_ret_vld  out  1  oldest entry is valid and committed
i_ret_rdy  in  1  dmem accepts retire this cycle
o_ret_addr  out  ADDR_W  retire address
o_ret_data  out  DATA_W  retire data
o_ret_be  out  BE_W  retire byte enables
i_ld_addr  in  ADDR_W  load lookup address
i_ld_be  in  BE_W  bytes the load needs
o_ld_hit  out  1  all requested bytes are covered by buffered stores
o_ld_partial  out  1  some but not all requested bytes are covered; load must replay
o_ld_data  out  DATA_W  merged forward data; uncovered lanes = 0
o_ld_fwd_be  out  BE_W  covered lanes, masked by i_ld_be

Behaviour:
- Pointers fin/com/ret are log2(DEPTH)+1 bits (wrap bit).
  - o_empty: fin == ret.
  - o_full: same index, wrap bits differ.
  - o_count: fin - ret.
- Reset:
  - All pointers 0; all valid/committed flags 0.
  - o_full=0, o_empty=1, o_count=0, o_ret_vld=0, o_ld_hit=0, o_ld_partial=0, o_ld_fwd_be=0, o_ld_data=0.
  - Reset mid-operation drops all entries, committed ones included.
- Allocate: i_fin_vld && !o_full writes addr/data/be at fin, sets valid, increments fin.
  - i_fin_vld while full is ignored and must not corrupt state.
- Commit: i_com_vld && com != fin sets committed at com, increments com.
  - Commit with no finished-uncommitted entry is ignored.
- Retire:
  - o_ret_vld = valid[ret] && committed[ret].
  - On o_ret_vld && i_ret_rdy: clear the entry's flags, increment ret.
  - o_ret_* stay stable while o_ret_vld && !i_ret_rdy.
- Flush: i_flush sets fin <= com_next, where com_next includes a same-cycle commit. Valid bits of discarded entries are cleared.
  - Flush wins over a same-cycle allocate; that allocate is dropped.
  - A same-cycle retire proceeds normally.
- Allocate, commit and retire may all occur in the same cycle. Allocate into a slot freed by a same-cycle retire is NOT allowed, because o_full is registered-state based.
- Forwarding: purely combinational from current registered state, same cycle as i_ld_addr.
  - Candidates: all valid entries (committed or not) whose word-aligned address matches.
  - Per byte lane: take data from the youngest candidate whose be covers that lane. Age is ordered from fin-1 back to ret, and must be correct across pointer wrap.
  - An entry retiring this cycle is still a candidate.
  - With i_ld_be == 0: hit=0, partial=0.
- Latency: allocate-to-forward visibility 1 cycle. Commit-to-o_ret_vld 1 cycle.

Optional Feature:
STBUF_FWD_EN
- Defined: forwarding as above.
- Undefined:
  - o_ld_hit=0, o_ld_data=0, o_ld_fwd_be=0.
  - o_ld_partial=1 whenever any valid entry word-matches and its be overlaps i_ld_be (conservative conflict; load replays).
  - The forwarding merge logic is not built.

Test Plan:
1. Reset, then allocate 8 stores (addr 0x100+4k, be 4'hF) with no commit -> o_full=1, o_count=8, o_ret_vld=0. 9th allocate ignored; count stays 8.
2. Commit 3, hold i_ret_rdy=0 two cycles, then 1 -> o_ret_vld=1 with addr 0x100 stable for 2 cycles. Then retires 0x100, 0x104, 0x108 in consecutive cycles; count 8->5.
3. Store 0x200 data 0x11223344 be 4'hF, then 0x200 data 0x000000AA be 4'h1. Load 0x202 be 4'hF -> hit=1, data 0x112233AA. Load with be 4'h3 and only the second store present -> partial=1.
4. 5 allocated, 2 committed; i_flush together with i_com_vld and i_fin_vld -> count=3, com==fin, new store dropped, committed entries still retire.
5. Drive 20 alloc/commit/retire cycles so pointers wrap, keeping 2 same-address stores across the wrap boundary -> forward returns the younger store's data.
6. Build without STBUF_FWD_EN and repeat 3 -> hit=0, partial=1, data=0.
